fft_result_serializer: RTL and testbench



---
 rtl/fft_result_serializer.sv | 162 ++++++++++++++++
 tb/tb_fft_result_serializer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_serializer.sv
// -----------------------------------------------------------------------------
// fft_result_serializer
//
// Consumer end of the 8-point radix-2 pipelined FFT datapath. Each handshake
// captures one frame of eight parallel W-bit results into a two-bank
// ping-pong store. Frames are then streamed out one word per clock over a
// valid/ready interface. The output can be reordered from the datapath's
// bit-reversed order into natural order.
//
// Parameters:
//   W        width of each result word
//   BIT_REV  1: output index i carries stored word bitrev3(i); 0: stored order
//
// Ports:
//   clk_1     system clock, rising edge
//   rst       asynchronous active-high reset
//   par_in    frame, word k at par_in[k*W +: W]
//   in_valid  par_in holds a complete frame
//   in_ready  a bank is free (depends on registered state only)
//   s_data    current serial word (0 while s_valid is low)
//   s_idx     output index of s_data within the frame
//   s_valid   s_data/s_idx/s_last are valid
//   s_ready   sink accepts the current word
//   s_last    high with output index 7
//   frame_cnt (FRAME_CNT_EN only) count of completed frames, wraps at 16 bits
//
// Optional feature: define FRAME_CNT_EN to add the frame_cnt output.
// -----------------------------------------------------------------------------
module fft_result_serializer #(
    parameter int W       = 8,
    parameter bit BIT_REV = 1'b1
) (
    input  logic           clk_1,
    input  logic           rst,
    input  logic [8*W-1:0] par_in,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   s_data,
    output logic [2:0]     s_idx,
    output logic           s_valid,
    input  logic           s_ready,
    output logic           s_last
`ifdef FRAME_CNT_EN
    ,
    output logic [15:0]    frame_cnt
`endif
);

    logic [W-1:0] bank_q [2][8];
    logic [W-1:0] bank_d [2][8];
    logic [1:0]   full_q;
    logic [1:0]   full_d;
    logic         wr_bank_q;
    logic         wr_bank_d;
    logic         rd_bank_q;
    logic         rd_bank_d;
    logic [2:0]   rd_cnt_q;
    logic [2:0]   rd_cnt_d;
    logic [2:0]   rd_pos_s;
    logic         accept_s;
    logic         xfer_s;
`ifdef FRAME_CNT_EN
    logic [15:0]  frame_cnt_q;
    logic [15:0]  frame_cnt_d;
`endif

    function automatic logic [2:0] bitrev3(input logic [2:0] i);
        return {i[0], i[1], i[2]};
    endfunction

    assign accept_s = in_valid & in_ready;
    assign xfer_s   = s_valid & s_ready;

    // Output side: muxed straight from the bank registers, zeroed while idle.
    always_comb begin
        in_ready = ~full_q[wr_bank_q];
        s_valid  = full_q[rd_bank_q];
        s_idx    = rd_cnt_q;
        rd_pos_s = BIT_REV ? bitrev3(rd_cnt_q) : rd_cnt_q;
        if (s_valid) begin
            s_data = bank_q[rd_bank_q][rd_pos_s];
            s_last = (rd_cnt_q == 3'd7);
        end else begin
            s_data = {W{1'b0}};
            s_last = 1'b0;
        end
    end

    // Next-state: accept and transfer always touch different banks, because
    // accept needs full[wr_bank]=0 and transfer needs full[rd_bank]=1.
    always_comb begin
        bank_d    = bank_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        if (accept_s) begin
            for (int k = 0; k < 8; k++) begin
                bank_d[wr_bank_q][k] = par_in[k*W +: W];
            end
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end else begin
            wr_bank_d = wr_bank_q;
        end
        if (xfer_s) begin
            if (rd_cnt_q == 3'd7) begin
                rd_cnt_d          = 3'd0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                rd_cnt_d = rd_cnt_q + 3'd1;
            end
        end else begin
            rd_cnt_d = rd_cnt_q;
        end
    end

    // State registers; reset discards any partially streamed frame.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 8; k++) begin
                    bank_q[b][k] <= {W{1'b0}};
                end
            end
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            rd_cnt_q  <= 3'd0;
        end else begin
            bank_q    <= bank_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

`ifdef FRAME_CNT_EN
    // Completed-frame count: bumps on the transfer of the last word.
    always_comb begin
        if (xfer_s && s_last) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_fft_result_serializer.sv
// Bench for fft_result_serializer: one instance with BIT_REV=1 and one with
// BIT_REV=0 share all inputs. Accepted frames push expected words to one
// scoreboard queue per instance. Transfers pop these words and compare them.
module tb_fft_result_serializer;

    typedef struct {
        logic [63:0] frame;
        logic [63:0] exp_rev;
        logic [63:0] exp_nat;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] idx;
        logic       last;
    } exp_t;

    logic        clk_1    = 1'b0;
    logic        rst      = 1'b1;
    logic [63:0] par_in   = 64'd0;
    logic        in_valid = 1'b0;
    logic        s_ready  = 1'b0;

    logic        in_ready, s_valid, s_last;
    logic [7:0]  s_data;
    logic [2:0]  s_idx;
    logic        in_ready_n, s_valid_n, s_last_n;
    logic [7:0]  s_data_n;
    logic [2:0]  s_idx_n;
`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt, frame_cnt_n;
`endif

    int          checks   = 0;
    int          failures = 0;
    int          acc_cnt  = 0;
    int          trf_cnt  = 0;
    logic [15:0] fc_model = 16'd0;
    exp_t        exp_rev_q[$];
    exp_t        exp_nat_q[$];
    vec_t        offer_q[$];

    fft_result_serializer #(.W(8), .BIT_REV(1'b1)) dut (
        .clk_1(clk_1), .rst(rst), .par_in(par_in), .in_valid(in_valid),
        .in_ready(in_ready), .s_data(s_data), .s_idx(s_idx), .s_valid(s_valid),
        .s_ready(s_ready), .s_last(s_last)
`ifdef FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    fft_result_serializer #(.W(8), .BIT_REV(1'b0)) dut_n (
        .clk_1(clk_1), .rst(rst), .par_in(par_in), .in_valid(in_valid),
        .in_ready(in_ready_n), .s_data(s_data_n), .s_idx(s_idx_n), .s_valid(s_valid_n),
        .s_ready(s_ready), .s_last(s_last_n)
`ifdef FRAME_CNT_EN
        , .frame_cnt(frame_cnt_n)
`endif
    );

    initial forever #5 clk_1 = ~clk_1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pk(input logic [7:0] w0, w1, w2, w3, w4, w5, w6, w7);
        return {w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer a frame and hold in_valid until the monitor sees it accepted.
    task automatic offer(input vec_t r);
        int start;
        int n;
        start = acc_cnt;
        n     = 0;
        offer_q.push_back(r);
        par_in   = r.frame;
        in_valid = 1'b1;
        while (acc_cnt == start && n < 200) begin
            @(posedge clk_1);
            n++;
        end
        #1;
        in_valid = 1'b0;
        chk("offer_accepted", 64'(acc_cnt - start), 64'd1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((s_valid || exp_rev_q.size() != 0) && n < budget) begin
            @(posedge clk_1);
            #1;
            n++;
        end
        chk("drain_idle", s_valid, 64'd0);
        chk("drain_empty", 64'(exp_rev_q.size()), 64'd0);
`ifdef FRAME_CNT_EN
        chk("frame_cnt", frame_cnt, fc_model);
        chk("frame_cnt_n", frame_cnt_n, fc_model);
`endif
    endtask

    // Monitor: sample on the falling edge, away from the active edge.
    initial begin : monitor
        exp_t       e;
        vec_t       r;
        logic       stall;
        logic [7:0] h_data, h_data_n;
        logic [2:0] h_idx;
        logic       h_last;
        stall = 1'b0;
        forever begin
            @(negedge clk_1);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (in_valid && in_ready) begin
                    acc_cnt++;
                    chk("accept_expected", 64'(offer_q.size() != 0), 64'd1);
                    if (offer_q.size() != 0) begin
                        r = offer_q.pop_front();
                        for (int i = 0; i < 8; i++) begin
                            e.idx  = 3'(i);
                            e.last = (i == 7);
                            e.data = r.exp_rev[i*8 +: 8];
                            exp_rev_q.push_back(e);
                            e.data = r.exp_nat[i*8 +: 8];
                            exp_nat_q.push_back(e);
                        end
                    end
                end
                chk("ready_match", in_ready_n, in_ready);
                chk("valid_match", s_valid_n, s_valid);
                if (stall && s_valid) begin
                    chk("hold_data", s_data, h_data);
                    chk("hold_data_n", s_data_n, h_data_n);
                    chk("hold_idx", s_idx, h_idx);
                    chk("hold_last", s_last, h_last);
                end
                stall    = s_valid && !s_ready;
                h_data   = s_data;
                h_data_n = s_data_n;
                h_idx    = s_idx;
                h_last   = s_last;
                if (s_valid && s_ready) begin
                    trf_cnt++;
                    chk("rev_pending", 64'(exp_rev_q.size() != 0), 64'd1);
                    if (exp_rev_q.size() != 0) begin
                        e = exp_rev_q.pop_front();
                        chk("rev_data", s_data, e.data);
                        chk("rev_idx", s_idx, e.idx);
                        chk("rev_last", s_last, e.last);
                        if (e.last) fc_model = fc_model + 16'd1;
                    end
                    if (exp_nat_q.size() != 0) begin
                        e = exp_nat_q.pop_front();
                        chk("nat_data", s_data_n, e.data);
                        chk("nat_idx", s_idx_n, e.idx);
                        chk("nat_last", s_last_n, e.last);
                    end
                end
            end
        end
    end

    initial begin : main
        vec_t tbl[6];
        int   n;
        int   n0;
        int   gap;

        tbl[0] = '{pk(8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07),
                   pk(8'h00, 8'h04, 8'h02, 8'h06, 8'h01, 8'h05, 8'h03, 8'h07),
                   pk(8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07)};
        tbl[1] = '{pk(8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h04, 8'h06, 8'h05),
                   pk(8'h03, 8'h07, 8'h01, 8'h06, 8'h02, 8'h04, 8'h08, 8'h05),
                   pk(8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h04, 8'h06, 8'h05)};
        tbl[2] = '{pk(8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00),
                   pk(8'h07, 8'h03, 8'h05, 8'h01, 8'h06, 8'h02, 8'h04, 8'h00),
                   pk(8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00)};
        tbl[3] = '{pk(8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00),
                   pk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00),
                   pk(8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00)};
        tbl[4] = '{pk(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80),
                   pk(8'h10, 8'h50, 8'h30, 8'h70, 8'h20, 8'h60, 8'h40, 8'h80),
                   pk(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80)};
        tbl[5] = '{pk(8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h11, 8'h22, 8'h33),
                   pk(8'hAA, 8'hEE, 8'hCC, 8'h22, 8'hBB, 8'h11, 8'hDD, 8'h33),
                   pk(8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h11, 8'h22, 8'h33)};

        // Reset state
        #12;
        chk("reset_in_ready", in_ready, 64'd1);
        chk("reset_s_valid", s_valid, 64'd0);
        chk("reset_s_data", s_data, 64'd0);
        chk("reset_s_idx", s_idx, 64'd0);
        chk("reset_s_last", s_last, 64'd0);
        @(posedge clk_1);
        #1;
        rst = 1'b0;

        // Table: frames back to back with the sink always ready
        s_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            offer(tbl[i]);
        end
        drain(200);

        // Backpressure: A and B fill both banks, C is held off
        s_ready = 1'b0;
        offer(tbl[1]);
        offer(tbl[2]);
        n0 = acc_cnt;
        offer_q.push_back(tbl[5]);
        par_in   = tbl[5].frame;
        in_valid = 1'b1;
        repeat (4) begin
            @(posedge clk_1);
            #1;
        end
        chk("bp_in_ready", in_ready, 64'd0);
        chk("bp_c_held", 64'(acc_cnt - n0), 64'd0);
        chk("bp_s_valid", s_valid, 64'd1);
        chk("bp_s_idx", s_idx, 64'd0);
        chk("bp_s_data", s_data, 64'h03);
        s_ready = 1'b1;
        gap     = 0;
        n       = 0;
        fork
            begin
                repeat (16) begin
                    @(negedge clk_1);
                    if (!s_valid) gap++;
                end
            end
            begin
                while (acc_cnt == n0 && n < 40) begin
                    @(posedge clk_1);
                    n++;
                end
                #1;
                in_valid = 1'b0;
            end
        join
        chk("bp_no_gap", 64'(gap), 64'd0);
        chk("bp_c_accept_cycle", 64'(n), 64'd9);
        drain(200);

        // s_ready toggling during a frame
        n0 = trf_cnt;
        offer(tbl[4]);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_1);
            #1;
            s_ready = ~s_ready;
        end
        s_ready = 1'b1;
        drain(200);
        chk("toggle_xfers", 64'(trf_cnt - n0), 64'd8);

        // Asynchronous reset after three words of a frame
        offer(tbl[0]);
        repeat (3) @(posedge clk_1);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_words_done", 64'(exp_rev_q.size()), 64'd5);
        chk("rst_s_valid", s_valid, 64'd0);
        chk("rst_s_data", s_data, 64'd0);
        chk("rst_s_idx", s_idx, 64'd0);
        chk("rst_s_last", s_last, 64'd0);
        chk("rst_in_ready", in_ready, 64'd1);
        exp_rev_q.delete();
        exp_nat_q.delete();
        offer_q.delete();
        fc_model = 16'd0;
        @(posedge clk_1);
        #1;
        rst = 1'b0;
        offer(tbl[3]);
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
